// File: rtl/cc_unit.sv
// Y86 condition-code unit: OPq flag register, cmovXX/jXX condition evaluation and a sticky freeze on a bad status.
// Optional CC_COUNT_EN adds upd_cnt/taken_cnt event counters.
module cc_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] alu_y,
    input  logic        alu_of,
    input  logic        stat_ok,
    output logic        zf,
    output logic        sf,
    output logic        of,
    output logic        cnd,
    output logic        frozen,
`ifdef CC_COUNT_EN
    output logic [31:0] upd_cnt,
    output logic [31:0] taken_cnt,
`endif
    output logic        bad_ifun
);

    // state  | meaning
    // RUN    | normal operation, OPq updates flags
    // FROZEN | bad status seen, flags locked until rst
    typedef enum logic [0:0] {RUN = 1'b0, FROZEN = 1'b1} state_t;

    state_t state_q, state_d;
    logic   zf_q, zf_d;
    logic   sf_q, sf_d;
    logic   of_q, of_d;
    logic   is_cond_op;
    logic   cond_raw;
    logic   upd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
        end
    end

    always_comb begin
        state_d = state_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        upd_en  = (state_q == RUN) && valid && stat_ok && (icode == 4'h6);
        if (state_q == RUN && valid && !stat_ok) begin
            state_d = FROZEN;
        end
        if (upd_en) begin
            zf_d = (alu_y == 64'd0);
            sf_d = alu_y[63];
            of_d = alu_of;
        end
    end

    // Condition is evaluated on the registered flags only, so an OPq in the
    // same cycle never influences it.
    always_comb begin
        is_cond_op = (icode == 4'h2) || (icode == 4'h7);
        cond_raw   = 1'b0;
        bad_ifun   = 1'b0;
        if (is_cond_op) begin
            case (ifun)
                4'd0:    cond_raw = 1'b1;
                4'd1:    cond_raw = (sf_q ^ of_q) | zf_q;
                4'd2:    cond_raw = sf_q ^ of_q;
                4'd3:    cond_raw = zf_q;
                4'd4:    cond_raw = ~zf_q;
                4'd5:    cond_raw = ~(sf_q ^ of_q);
                4'd6:    cond_raw = ~(sf_q ^ of_q) & ~zf_q;
                default: bad_ifun = 1'b1;
            endcase
        end
        cnd = valid & cond_raw;
    end

`ifdef CC_COUNT_EN
    logic [31:0] upd_cnt_q, upd_cnt_d;
    logic [31:0] taken_cnt_q, taken_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt_q   <= 32'd0;
            taken_cnt_q <= 32'd0;
        end else begin
            upd_cnt_q   <= upd_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    always_comb begin
        upd_cnt_d   = upd_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (upd_en) begin
            upd_cnt_d = upd_cnt_q + 32'd1;
        end
        if (state_q == RUN && is_cond_op && cnd) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
        end
    end

    assign upd_cnt   = upd_cnt_q;
    assign taken_cnt = taken_cnt_q;
`endif

    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;
    assign frozen = (state_q == FROZEN);

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit; counter checks compile in when CC_COUNT_EN is defined.
module tb_cc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] alu_y;
    logic        alu_of;
    logic        stat_ok;
    logic        zf, sf, of, cnd, frozen, bad_ifun;
`ifdef CC_COUNT_EN
    logic [31:0] upd_cnt, taken_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    cc_unit dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .icode    (icode),
        .ifun     (ifun),
        .alu_y    (alu_y),
        .alu_of   (alu_of),
        .stat_ok  (stat_ok),
        .zf       (zf),
        .sf       (sf),
        .of       (of),
        .cnd      (cnd),
        .frozen   (frozen),
`ifdef CC_COUNT_EN
        .upd_cnt  (upd_cnt),
        .taken_cnt(taken_cnt),
`endif
        .bad_ifun (bad_ifun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] y, input logic ofl, input logic ok);
        valid   = v;
        icode   = ic;
        ifun    = fn;
        alu_y   = y;
        alu_of  = ofl;
        stat_ok = ok;
        #1;
    endtask

    // Inputs are sampled by exactly one edge per tick; state is read 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic ez, input logic es, input logic eo);
        check({tag, "_zf"}, {63'd0, zf}, {63'd0, ez});
        check({tag, "_sf"}, {63'd0, sf}, {63'd0, es});
        check({tag, "_of"}, {63'd0, of}, {63'd0, eo});
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 64'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        check_flags("reset", 1'b1, 1'b0, 1'b0);
        check("reset_frozen", {63'd0, frozen}, 64'd0);

        drive(1'b1, 4'h7, 4'h3, 64'd0, 1'b0, 1'b1);
        check("je_after_reset", {63'd0, cnd}, 64'd1);
        check("je_bad_ifun", {63'd0, bad_ifun}, 64'd0);
        tick();

        drive(1'b1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        check("opq_cnd_zero", {63'd0, cnd}, 64'd0);
        check("opq_flags_not_yet", {63'd0, zf}, 64'd1);
        tick();
        check_flags("opq_neg", 1'b0, 1'b1, 1'b0);

        drive(1'b1, 4'h7, 4'h2, 64'd0, 1'b0, 1'b1);
        check("jl_neg", {63'd0, cnd}, 64'd1);
        drive(1'b1, 4'h7, 4'h6, 64'd0, 1'b0, 1'b1);
        check("jg_neg", {63'd0, cnd}, 64'd0);
        drive(1'b1, 4'h2, 4'h4, 64'd0, 1'b0, 1'b1);
        check("cmovne_neg", {63'd0, cnd}, 64'd1);
        tick();

        drive(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
        tick();
        check_flags("opq_ovf", 1'b0, 1'b1, 1'b1);

        drive(1'b1, 4'h7, 4'h5, 64'd0, 1'b0, 1'b1);
        check("jge_ovf", {63'd0, cnd}, 64'd1);
        drive(1'b1, 4'h7, 4'h1, 64'd0, 1'b0, 1'b1);
        check("jle_ovf", {63'd0, cnd}, 64'd0);
        drive(1'b1, 4'h7, 4'h6, 64'd0, 1'b0, 1'b1);
        check("jg_ovf", {63'd0, cnd}, 64'd1);
        drive(1'b1, 4'h7, 4'h3, 64'd0, 1'b0, 1'b1);
        check("je_ovf", {63'd0, cnd}, 64'd0);
        drive(1'b0, 4'h7, 4'h0, 64'd0, 1'b0, 1'b1);
        check("jmp_invalid", {63'd0, cnd}, 64'd0);

        drive(1'b1, 4'h2, 4'h9, 64'd0, 1'b0, 1'b1);
        check("bad_cnd", {63'd0, cnd}, 64'd0);
        check("bad_flag", {63'd0, bad_ifun}, 64'd1);
        drive(1'b1, 4'h6, 4'h0, 64'd5, 1'b0, 1'b1);
        check("opq_not_cond_cnd", {63'd0, cnd}, 64'd0);
        check("opq_not_cond_bad", {63'd0, bad_ifun}, 64'd0);
        valid = 1'b0;
        #1;
        tick();
        check_flags("idle_hold", 1'b0, 1'b1, 1'b1);

        // Freezing edge carries an OPq with alu_y=0 that must not land.
        drive(1'b1, 4'h6, 4'h0, 64'd0, 1'b0, 1'b0);
        tick();
        check("frozen_set", {63'd0, frozen}, 64'd1);
        check_flags("freeze_edge", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 4'h6, 4'h0, 64'd0, 1'b0, 1'b1);
        tick();
        check_flags("frozen_opq", 1'b0, 1'b1, 1'b1);
        check("frozen_stays", {63'd0, frozen}, 64'd1);

        rst = 1'b1;
        drive(1'b1, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        check("rst_unfreeze", {63'd0, frozen}, 64'd0);
        check_flags("rst_from_frozen", 1'b1, 1'b0, 1'b0);

        rst = 1'b1;
        drive(1'b1, 4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        check_flags("rst_over_opq", 1'b1, 1'b0, 1'b0);
        check("rst_over_opq_frozen", {63'd0, frozen}, 64'd0);

`ifdef CC_COUNT_EN
        drive(1'b0, 4'h0, 4'h0, 64'd0, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b1, 4'h6, 4'h0, 64'd1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        drive(1'b1, 4'h7, 4'h0, 64'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'h2, 4'h4, 64'd0, 1'b0, 1'b1);
        tick();
        drive(1'b1, 4'h7, 4'h3, 64'd0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'h7, 4'h0, 64'd0, 1'b0, 1'b1);
        tick();
        check("upd_cnt", {32'd0, upd_cnt}, 64'd3);
        check("taken_cnt", {32'd0, taken_cnt}, 64'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("upd_cnt_rst", {32'd0, upd_cnt}, 64'd0);
        check("taken_cnt_rst", {32'd0, taken_cnt}, 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
